matrix_loader: RTL and testbench

- Receiving end of the matrix-traversal interface: accepts a serial stream of elements in row-major order and assembles them into a SIZE x SIZE register buffer.
- Tracks its own write (i, j) position, which wraps the same way the traversal index counters do.
- Presents the completed matrix to the downstream convolution stage with a valid/ready handshake.
- Feeds kernel and window buffers from a serial source (memory reader, UART deserializer).

---
 rtl/matrix_loader_if.sv | 25 ++
 rtl/matrix_loader.sv | 96 +++++++++
 tb/tb_matrix_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_loader_if.sv
// Element-stream and matrix handshake bundle between the loader and its neighbours.
// The master side drives elements in and consumes matrices. The slave side is the loader.
interface matrix_loader_if #(
    parameter int SIZE      = 3,
    parameter int WIDTH_BIT = 8
);
    logic                            in_valid;
    logic [WIDTH_BIT-1:0]            in_data;
    logic                            in_ready;
    logic                            mat_valid;
    logic                            mat_ready;
    logic [SIZE*SIZE*WIDTH_BIT-1:0]  mat_data;
    logic [WIDTH_BIT-1:0]            i;
    logic [WIDTH_BIT-1:0]            j;

    modport master (
        output in_valid, in_data, mat_ready,
        input  in_ready, mat_valid, mat_data, i, j
    );

    modport slave (
        input  in_valid, in_data, mat_ready,
        output in_ready, mat_valid, mat_data, i, j
    );
endinterface

// File: rtl/matrix_loader.sv
// Assembles a row-major element stream into a SIZE x SIZE buffer; mat_valid 1 cycle after the last accept.
// Backpressure: in_ready low while a finished matrix waits in HOLD for mat_ready.
module matrix_loader #(
    parameter int SIZE      = 3,
    parameter int WIDTH_BIT = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    matrix_loader_if.slave bus
);
    localparam int N = SIZE * SIZE;
    localparam logic [WIDTH_BIT-1:0] LAST = WIDTH_BIT'(SIZE - 1);
    localparam logic [WIDTH_BIT-1:0] ONE  = WIDTH_BIT'(1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [WIDTH_BIT-1:0]     i_q, i_d, j_q, j_d;
    logic                     valid_q, valid_d;
    logic [N*WIDTH_BIT-1:0]   buf_q, buf_d;

    logic                     in_ready;
    logic                     accept;
    logic [WIDTH_BIT-1:0]     i_eff, j_eff;
    int                       widx;

    assign in_ready = (state_q == FILL) && !reset;
    assign accept   = bus.in_valid && in_ready;

    // Out-of-range indices cannot occur, but fold them to 0 so a write can never miss the buffer.
    assign i_eff = (i_q > LAST) ? '0 : i_q;
    assign j_eff = (j_q > LAST) ? '0 : j_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        widx    = int'(i_eff) * SIZE + int'(j_eff);

        if (flush) begin
            i_d     = '0;
            j_d     = '0;
            valid_d = 1'b0;
            state_d = FILL;
        end else if (state_q == FILL) begin
            if (accept) begin
                for (int e = 0; e < N; e++) begin
                    if (e == widx) begin
                        buf_d[e*WIDTH_BIT +: WIDTH_BIT] = bus.in_data;
                    end
                end
                if (j_eff == LAST) begin
                    j_d = '0;
                    if (i_eff == LAST) begin
                        i_d     = '0;
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end else begin
                        i_d = i_eff + ONE;
                    end
                end else begin
                    i_d = i_eff;
                    j_d = j_eff + ONE;
                end
            end
        end else if (bus.mat_ready) begin
            valid_d = 1'b0;
            state_d = FILL;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL;
            i_q     <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mat_valid = valid_q;
    assign bus.mat_data  = buf_q;
    assign bus.i         = i_q;
    assign bus.j         = j_q;
endmodule

// File: tb/tb_matrix_loader.sv
// Directed checks of matrix_loader (SIZE=3, WIDTH_BIT=8) with hand-computed expectations.
module tb_matrix_loader;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    matrix_loader_if #(.SIZE(3), .WIDTH_BIT(8)) bus ();

    matrix_loader #(.SIZE(3), .WIDTH_BIT(8)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.mat_ready = 1'b0;
        reset = 1'b1;
        tick();
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_vec++; if (bus.mat_valid !== 1'b0) begin n_err++; $display("FAIL reset_mat_valid got %b want 0", bus.mat_valid); end
        n_vec++; if (bus.mat_data !== 72'h0) begin n_err++; $display("FAIL reset_mat_data got %h want 0", bus.mat_data); end
        n_vec++; if (bus.i !== 8'd0 || bus.j !== 8'd0) begin n_err++; $display("FAIL reset_ij got %0d,%0d want 0,0", bus.i, bus.j); end
        reset = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic_fill();
        logic [7:0] ei, ej;
        for (int k = 0; k < 9; k++) begin
            ei = 8'(k / 3);
            ej = 8'(k % 3);
            n_vec++; if (bus.i !== ei || bus.j !== ej) begin n_err++; $display("FAIL fill_ij k=%0d got %0d,%0d want %0d,%0d", k, bus.i, bus.j, ei, ej); end
            n_vec++; if (bus.mat_valid !== 1'b0) begin n_err++; $display("FAIL fill_early_valid k=%0d got %b want 0", k, bus.mat_valid); end
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(k + 1);
            tick();
        end
        bus.in_valid = 1'b0;
        n_vec++; if (bus.mat_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid got %b want 1", bus.mat_valid); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fill_hold_ready got %b want 0", bus.in_ready); end
        n_vec++; if (bus.i !== 8'd0 || bus.j !== 8'd0) begin n_err++; $display("FAIL fill_wrap_ij got %0d,%0d want 0,0", bus.i, bus.j); end
        n_vec++; if (bus.mat_data !== 72'h090807060504030201) begin n_err++; $display("FAIL fill_data got %h want 090807060504030201", bus.mat_data); end
    endtask

    task automatic test_backpressure();
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hAA;
        bus.mat_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++; if (bus.in_ready !== 1'b0 || bus.mat_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold c=%0d ready=%b valid=%b want 0,1", c, bus.in_ready, bus.mat_valid); end
            n_vec++; if (bus.mat_data !== 72'h090807060504030201) begin n_err++; $display("FAIL bp_data c=%0d got %h want 090807060504030201", c, bus.mat_data); end
        end
        bus.mat_ready = 1'b1;
        tick();
        bus.mat_ready = 1'b0;
        n_vec++; if (bus.mat_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_consume valid=%b ready=%b want 0,1", bus.mat_valid, bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_vec++; if (bus.mat_data[7:0] !== 8'hAA || bus.j !== 8'd1 || bus.i !== 8'd0) begin n_err++; $display("FAIL bp_accept e00=%h i=%0d j=%0d want aa,0,1", bus.mat_data[7:0], bus.i, bus.j); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h21 + k);
            tick();
        end
        n_vec++; if (bus.i !== 8'd1 || bus.j !== 8'd2) begin n_err++; $display("FAIL flush_pre_ij got %0d,%0d want 1,2", bus.i, bus.j); end
        flush = 1'b1;
        bus.in_data = 8'h55;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_vec++; if (bus.i !== 8'd0 || bus.j !== 8'd0 || bus.mat_valid !== 1'b0) begin n_err++; $display("FAIL flush_ij got %0d,%0d valid=%b want 0,0,0", bus.i, bus.j, bus.mat_valid); end
        n_vec++; if (bus.mat_data[47:40] !== 8'h06) begin n_err++; $display("FAIL flush_drop e12=%h want 06", bus.mat_data[47:40]); end
        for (int k = 0; k < 9; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        n_vec++; if (bus.mat_valid !== 1'b1) begin n_err++; $display("FAIL flush_refill_valid got %b want 1", bus.mat_valid); end
        n_vec++; if (bus.mat_data !== 72'h181716151413121110) begin n_err++; $display("FAIL flush_refill_data got %h want 181716151413121110", bus.mat_data); end
        bus.mat_ready = 1'b1;
        tick();
        bus.mat_ready = 1'b0;
    endtask

    task automatic test_gapped();
        int acc;
        logic [7:0] ei, ej;
        for (int k = 0; k < 18; k++) begin
            acc = (k + 1) / 2;
            ei  = 8'((acc % 9) / 3);
            ej  = 8'(acc % 3);
            n_vec++; if (bus.i !== ei || bus.j !== ej) begin n_err++; $display("FAIL gap_ij k=%0d got %0d,%0d want %0d,%0d", k, bus.i, bus.j, ei, ej); end
            n_vec++; if (bus.mat_valid !== (k == 17)) begin n_err++; $display("FAIL gap_valid k=%0d got %b want %b", k, bus.mat_valid, (k == 17)); end
            bus.in_valid = (k % 2 == 0);
            bus.in_data  = 8'(8'h30 + k / 2);
            tick();
        end
        bus.in_valid = 1'b0;
        n_vec++; if (bus.mat_data !== 72'h383736353433323130) begin n_err++; $display("FAIL gap_data got %h want 383736353433323130", bus.mat_data); end
    endtask

    task automatic test_reset_hold();
        n_vec++; if (bus.mat_valid !== 1'b1) begin n_err++; $display("FAIL rh_pre_valid got %b want 1", bus.mat_valid); end
        reset = 1'b1;
        tick();
        n_vec++; if (bus.mat_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rh_during valid=%b ready=%b want 0,0", bus.mat_valid, bus.in_ready); end
        n_vec++; if (bus.mat_data !== 72'h0 || bus.i !== 8'd0 || bus.j !== 8'd0) begin n_err++; $display("FAIL rh_clear data=%h i=%0d j=%0d want 0", bus.mat_data, bus.i, bus.j); end
        reset = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rh_release got %b want 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        int   sent   = 0;
        int   pulses = 0;
        int   cyc    = 0;
        logic exp_valid = 1'b0;
        logic exp_next;
        bus.mat_ready = 1'b1;
        while (pulses < 2 && cyc < 40) begin
            n_vec++; if (bus.mat_valid !== exp_valid || bus.in_ready !== !exp_valid) begin n_err++; $display("FAIL b2b_cyc%0d valid=%b ready=%b want %b,%b", cyc, bus.mat_valid, bus.in_ready, exp_valid, !exp_valid); end
            if (exp_valid) begin
                pulses++;
                n_vec++;
                if (bus.mat_data !== ((pulses == 1) ? 72'h484746454443424140 : 72'h51504f4e4d4c4b4a49)) begin
                    n_err++; $display("FAIL b2b_data pulse=%0d got %h", pulses, bus.mat_data);
                end
            end
            bus.in_valid = (sent < 18);
            bus.in_data  = 8'(8'h40 + sent);
            exp_next = 1'b0;
            if (bus.in_valid && !exp_valid) begin
                sent++;
                exp_next = (sent % 9 == 0);
            end
            if (pulses < 2) begin
                tick();
                exp_valid = exp_next;
            end
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.mat_ready = 1'b0;
        n_vec++; if (pulses != 2) begin n_err++; $display("FAIL b2b_pulses got %0d want 2 within %0d cycles", pulses, cyc); end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_flush();
        test_gapped();
        test_reset_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
